// File: rtl/wb_pkg.sv
// Shared field layout for the writeback bus: {data, addr, regW}, regW in bit 0.
// Offsets are fixed; widths below are the default configuration.
package wb_pkg;

   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned WB_BUS_W   = DATA_W_DEF + ADDR_W_DEF + 1;

   localparam int unsigned REGW_BIT   = 0;
   localparam int unsigned ADDR_LSB   = 1;
   localparam int unsigned DATA_LSB   = ADDR_W_DEF + 1;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
      logic [ADDR_W_DEF-1:0] addr;
      logic                  regw;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous in-order FIFO with occupancy count and exposed storage
// so the owner can scan pending entries.
module wb_fifo #(
   parameter int unsigned W     = 38,
   parameter int unsigned DEPTH = 4
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic [W-1:0]                   i_wdata,
   input  logic                           i_push,
   input  logic                           i_pop,
   output logic [W-1:0]                   o_rdata,
   output logic                           o_full,
   output logic                           o_empty,
   output logic [$clog2(DEPTH):0]         o_count,
   output logic [$clog2(DEPTH)-1:0]       o_rd_ptr,
   output logic [DEPTH-1:0][W-1:0]        o_mem
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [DEPTH-1:0][W-1:0] r_mem;
   logic [PW-1:0]           r_wr_ptr;
   logic [PW-1:0]           r_rd_ptr;
   logic [CW-1:0]           r_count;
   logic                    w_push;
   logic                    w_pop;

   // Full blocks pushes even if a pop is happening this cycle.
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop  && !o_empty;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   assign o_rdata  = r_mem[r_rd_ptr];
   assign o_count  = r_count;
   assign o_rd_ptr = r_rd_ptr;
   assign o_mem    = r_mem;

endmodule

// File: rtl/wbu_buf.sv
// Writeback queue between MEM and the ID register-file write port, with
// forwarding lookup over pending entries and a registered retire pulse to IF.
module wbu_buf
   import wb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DATA_WIDTH+ADDR_WIDTH:0]   mem_to_wb_bus,
   input  logic                             mem_to_wb_valid,
   output logic                             wb_to_mem_ready,
   output logic [DATA_WIDTH+ADDR_WIDTH:0]   wb_to_id_bus,
   output logic                             wb_to_id_valid,
   input  logic                             id_to_wb_ready,
   input  logic [ADDR_WIDTH-1:0]            fwd_addr,
   output logic                             fwd_hit,
   output logic [DATA_WIDTH-1:0]            fwd_data,
   output logic [$clog2(DEPTH):0]           wb_count,
   output logic                             wb_to_if_done
);

   localparam int unsigned BW    = DATA_WIDTH + ADDR_WIDTH + 1;
   localparam int unsigned PW    = $clog2(DEPTH);
   localparam int unsigned CW    = PW + 1;
   localparam int unsigned D_LSB = ADDR_WIDTH + 1;

   logic                     w_full;
   logic                     w_empty;
   logic                     w_push;
   logic                     w_pop;
   logic [CW-1:0]            w_count;
   logic [PW-1:0]            w_rd_ptr;
   logic [DEPTH-1:0][BW-1:0] w_mem;
   logic [PW-1:0]            w_idx;
   logic [BW-1:0]            w_ent;
   logic                     w_hit;
   logic [DATA_WIDTH-1:0]    w_fdata;
   logic                     r_done;

   assign wb_to_mem_ready = !w_full;
   assign wb_to_id_valid  = !w_empty;
   assign w_push          = mem_to_wb_valid && wb_to_mem_ready;
   assign w_pop           = wb_to_id_valid && id_to_wb_ready;

   wb_fifo #(
      .W     (BW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_wdata  (mem_to_wb_bus),
      .i_push   (w_push),
      .i_pop    (w_pop),
      .o_rdata  (wb_to_id_bus),
      .o_full   (w_full),
      .o_empty  (w_empty),
      .o_count  (w_count),
      .o_rd_ptr (w_rd_ptr),
      .o_mem    (w_mem)
   );

   // Scan oldest to youngest; later matches overwrite, so the youngest wins.
   always_comb begin
      w_hit   = 1'b0;
      w_fdata = '0;
      w_idx   = '0;
      w_ent   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         w_idx = w_rd_ptr + PW'(i);
         w_ent = w_mem[w_idx];
         if ((CW'(i) < w_count) && w_ent[REGW_BIT] && (fwd_addr != '0) &&
             (w_ent[ADDR_LSB +: ADDR_WIDTH] == fwd_addr)) begin
            w_hit   = 1'b1;
            w_fdata = w_ent[D_LSB +: DATA_WIDTH];
         end
      end
   end

   assign fwd_hit  = w_hit;
   assign fwd_data = w_fdata;
   assign wb_count = w_count;

   always_ff @(posedge clk) begin
      if (rst) r_done <= 1'b1;
      else     r_done <= w_pop;
   end

   assign wb_to_if_done = r_done;

endmodule

// File: tb/tb_wbu_buf.sv
// Directed-vector bench for wbu_buf at default widths and DEPTH=4.
module tb_wbu_buf;

   logic        clk = 1'b0;
   logic        rst;
   logic [37:0] mem_to_wb_bus;
   logic        mem_to_wb_valid;
   logic        wb_to_mem_ready;
   logic [37:0] wb_to_id_bus;
   logic        wb_to_id_valid;
   logic        id_to_wb_ready;
   logic [4:0]  fwd_addr;
   logic        fwd_hit;
   logic [31:0] fwd_data;
   logic [2:0]  wb_count;
   logic        wb_to_if_done;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wbu_buf #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .DEPTH(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .mem_to_wb_bus   (mem_to_wb_bus),
      .mem_to_wb_valid (mem_to_wb_valid),
      .wb_to_mem_ready (wb_to_mem_ready),
      .wb_to_id_bus    (wb_to_id_bus),
      .wb_to_id_valid  (wb_to_id_valid),
      .id_to_wb_ready  (id_to_wb_ready),
      .fwd_addr        (fwd_addr),
      .fwd_hit         (fwd_hit),
      .fwd_data        (fwd_data),
      .wb_count        (wb_count),
      .wb_to_if_done   (wb_to_if_done)
   );

   typedef struct {
      logic        rst, v;
      logic [37:0] bus;
      logic        rdy;
      logic [4:0]  fa;
      logic        e_ready, e_valid;
      logic [37:0] e_bus;
      logic        e_hit;
      logic [31:0] e_fd;
      logic [2:0]  e_cnt;
      logic        e_done;
   } vec_t;

   vec_t tbl [22];

   function automatic logic [37:0] mk(input logic [31:0] d, input logic [4:0] a, input logic w);
      return {d, a, w};
   endfunction

   function automatic vec_t mkv(input logic r, input logic v, input logic [37:0] b, input logic rd,
                                input logic [4:0] fa, input logic er, input logic ev,
                                input logic [37:0] eb, input logic eh, input logic [31:0] efd,
                                input logic [2:0] ec, input logic ed);
      vec_t t;
      t.rst = r; t.v = v; t.bus = b; t.rdy = rd; t.fa = fa;
      t.e_ready = er; t.e_valid = ev; t.e_bus = eb; t.e_hit = eh;
      t.e_fd = efd; t.e_cnt = ec; t.e_done = ed;
      return t;
   endfunction

   task automatic cmp(input string tag, input string f, input logic [37:0] got, input logic [37:0] exp);
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s %s: got %h expected %h", tag, f, got, exp);
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic [37:0] b, input logic rd,
                        input logic [4:0] fa);
      rst = r; mem_to_wb_valid = v; mem_to_wb_bus = b; id_to_wb_ready = rd; fwd_addr = fa;
   endtask

   task automatic check(input string tag, input vec_t t);
      n_vec++;
      cmp(tag, "ready", 38'(wb_to_mem_ready), 38'(t.e_ready));
      cmp(tag, "valid", 38'(wb_to_id_valid),  38'(t.e_valid));
      if (t.e_valid) cmp(tag, "bus", wb_to_id_bus, t.e_bus);
      cmp(tag, "hit",   38'(fwd_hit),         38'(t.e_hit));
      cmp(tag, "fdata", 38'(fwd_data),        38'(t.e_fd));
      cmp(tag, "count", 38'(wb_count),        38'(t.e_cnt));
      cmp(tag, "done",  38'(wb_to_if_done),   38'(t.e_done));
   endtask

   initial begin
      logic [37:0] A, B, C, D, E, F1, F2, F3, F4, X;
      vec_t        w;
      A  = mk(32'h11, 5'd1, 1'b1);  B  = mk(32'h22, 5'd2, 1'b1);
      C  = mk(32'h33, 5'd3, 1'b1);  D  = mk(32'h44, 5'd4, 1'b1);
      E  = mk(32'h55, 5'd5, 1'b1);
      F1 = mk(32'hAA, 5'd5, 1'b1);  F2 = mk(32'hBB, 5'd5, 1'b1);
      F3 = mk(32'hCC, 5'd5, 1'b0);  F4 = mk(32'h99, 5'd0, 1'b1);
      X  = '0;

      // rst, v, bus, rdy, fa | ready, valid, bus, hit, fdata, count, done (before the edge)
      tbl[0]  = mkv(0,0,X ,0,0,  1,0,X ,0,32'h00,0,1);
      tbl[1]  = mkv(0,1,A ,0,1,  1,0,X ,0,32'h00,0,0);
      tbl[2]  = mkv(0,1,B ,0,1,  1,1,A ,1,32'h11,1,0);
      tbl[3]  = mkv(0,1,C ,0,2,  1,1,A ,1,32'h22,2,0);
      tbl[4]  = mkv(0,1,D ,0,4,  1,1,A ,0,32'h00,3,0);
      tbl[5]  = mkv(0,1,E ,0,4,  0,1,A ,1,32'h44,4,0);
      tbl[6]  = mkv(0,1,E ,1,5,  0,1,A ,0,32'h00,4,0);
      tbl[7]  = mkv(0,0,X ,0,0,  1,1,B ,0,32'h00,3,1);
      tbl[8]  = mkv(0,0,X ,1,0,  1,1,B ,0,32'h00,3,0);
      tbl[9]  = mkv(0,0,X ,1,0,  1,1,C ,0,32'h00,2,1);
      tbl[10] = mkv(0,0,X ,1,0,  1,1,D ,0,32'h00,1,1);
      tbl[11] = mkv(0,0,X ,0,0,  1,0,X ,0,32'h00,0,1);
      tbl[12] = mkv(0,0,X ,0,0,  1,0,X ,0,32'h00,0,0);
      tbl[13] = mkv(0,1,F1,0,5,  1,0,X ,0,32'h00,0,0);
      tbl[14] = mkv(0,1,F2,0,5,  1,1,F1,1,32'hAA,1,0);
      tbl[15] = mkv(0,1,F3,0,5,  1,1,F1,1,32'hBB,2,0);
      tbl[16] = mkv(0,1,F4,0,5,  1,1,F1,1,32'hBB,3,0);
      tbl[17] = mkv(0,0,X ,0,0,  0,1,F1,0,32'h00,4,0);
      tbl[18] = mkv(0,0,X ,1,5,  0,1,F1,1,32'hBB,4,0);
      tbl[19] = mkv(1,0,X ,1,5,  1,1,F2,1,32'hBB,3,1);
      tbl[20] = mkv(0,0,X ,1,5,  1,0,X ,0,32'h00,0,1);
      tbl[21] = mkv(0,0,X ,1,5,  1,0,X ,0,32'h00,0,0);

      drive(1'b1, 1'b0, X, 1'b0, 5'd0);
      repeat (2) @(posedge clk);

      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         drive(tbl[i].rst, tbl[i].v, tbl[i].bus, tbl[i].rdy, tbl[i].fa);
         #1;
         check($sformatf("vec%0d", i), tbl[i]);
      end

      // Streaming push+pop across two pointer wraps; forward the entry at the head.
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         drive(1'b0, 1'b1, mk(32'h100 + 32'(k), 5'(k + 1), 1'b1), 1'b1, 5'(k));
         #1;
         w = mkv(0,0,X,0,0, 1, (k > 0), mk(32'h100 + 32'(k) - 32'd1, 5'(k), 1'b1),
                 (k > 0), (k > 0) ? 32'h100 + 32'(k) - 32'd1 : 32'h0,
                 (k > 0) ? 3'd1 : 3'd0, (k >= 2));
         check($sformatf("wrap%0d", k), w);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, X, 1'b1, 5'd0);
      #1;
      check("wrap_tail0", mkv(0,0,X,0,0, 1,1,mk(32'h109,5'd10,1'b1),0,32'h0,1,1));
      @(negedge clk);
      #1;
      check("wrap_tail1", mkv(0,0,X,0,0, 1,0,X,0,32'h0,0,1));
      @(negedge clk);
      #1;
      check("wrap_tail2", mkv(0,0,X,0,0, 1,0,X,0,32'h0,0,0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
